// File: rtl/tcpc_reg_bank_if.sv
// Register-access channel between the client arbiter and the TCPC register bank.
interface tcpc_reg_bank_if;
    logic       REQUEST;
    logic       RNW;
    logic [7:0] ADDR;
    logic [7:0] WR_DATA;
    logic       ACK;
    logic [7:0] RD_DATA;

    modport master (output REQUEST, RNW, ADDR, WR_DATA, input ACK, RD_DATA);
    modport slave  (input REQUEST, RNW, ADDR, WR_DATA, output ACK, RD_DATA);
endinterface

// File: rtl/tcpc_reg_bank.sv
// TCPC register bank: four-phase register access, alert collection and
// ALERT_N generation, control register export to the Tx/Rx/HardReset/CC logic.
module tcpc_reg_bank #(
    parameter logic [15:0] VENDOR_ID  = 16'h0000,
    parameter logic [15:0] PRODUCT_ID = 16'h0000,
    parameter int          ACK_DELAY  = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    tcpc_reg_bank_if.slave bus,
    input  logic [15:0] ALERT_SET,
    input  logic [7:0]  CC_STATUS_IN,
    output logic [7:0]  TCPC_CONTROL,
    output logic [7:0]  ROLE_CONTROL,
    output logic [7:0]  RECEIVE_DETECT,
    output logic [7:0]  TRANSMIT,
    output logic        TRANSMIT_STB,
    output logic        ALERT_N
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture, do_access;

    logic        cap_rnw;
    logic [7:0]  cap_addr;
    logic [7:0]  cap_wdata;

    logic [15:0] alert, alert_mask;
    logic [15:0] clear_mask;
    logic [7:0]  rd_val;
    logic        wr_en;

    // Handshake state register and wait counter
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: one access per REQUEST high period
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.REQUEST) begin
                    capture = 1'b1;
                    cnt_d   = 4'(ACK_DELAY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!bus.REQUEST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch bus inputs at request capture; later bus activity is ignored
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cap_rnw   <= 1'b1;
            cap_addr  <= 8'h00;
            cap_wdata <= 8'h00;
        end else if (capture) begin
            cap_rnw   <= bus.RNW;
            cap_addr  <= bus.ADDR;
            cap_wdata <= bus.WR_DATA;
        end
    end

    assign wr_en = do_access && !cap_rnw;

    // Read mux over pre-update register values
    always_comb begin
        rd_val = 8'h00;
        case (cap_addr)
            8'h00: rd_val = VENDOR_ID[7:0];
            8'h01: rd_val = VENDOR_ID[15:8];
            8'h02: rd_val = PRODUCT_ID[7:0];
            8'h03: rd_val = PRODUCT_ID[15:8];
            8'h10: rd_val = alert[7:0];
            8'h11: rd_val = alert[15:8];
            8'h12: rd_val = alert_mask[7:0];
            8'h13: rd_val = alert_mask[15:8];
            8'h19: rd_val = TCPC_CONTROL;
            8'h1A: rd_val = ROLE_CONTROL;
            8'h1D: rd_val = CC_STATUS_IN;
            8'h2F: rd_val = RECEIVE_DETECT;
            8'h50: rd_val = TRANSMIT;
            default: rd_val = 8'h00;
        endcase
    end

    // Write-1-to-clear mask, only live on the write edge to the ALERT bytes
    always_comb begin
        clear_mask = 16'h0000;
        if (wr_en && cap_addr == 8'h10) clear_mask = {8'h00, cap_wdata};
        if (wr_en && cap_addr == 8'h11) clear_mask = {cap_wdata, 8'h00};
    end

    // ACK / RD_DATA: raise on the access edge, drop once REQUEST is released
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bus.ACK     <= 1'b0;
            bus.RD_DATA <= 8'h00;
        end else if (do_access) begin
            bus.ACK     <= 1'b1;
            bus.RD_DATA <= cap_rnw ? rd_val : 8'h00;
        end else if (state_q == DONE && !bus.REQUEST) begin
            bus.ACK     <= 1'b0;
            bus.RD_DATA <= 8'h00;
        end
    end

    // Register storage; ALERT set events win over a same-edge clear
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            alert          <= 16'h0000;
            alert_mask     <= 16'h7FFF;
            TCPC_CONTROL   <= 8'h00;
            ROLE_CONTROL   <= 8'h0A;
            RECEIVE_DETECT <= 8'h00;
            TRANSMIT       <= 8'h00;
            TRANSMIT_STB   <= 1'b0;
        end else begin
            alert        <= (alert & ~clear_mask) | ALERT_SET;
            TRANSMIT_STB <= wr_en && (cap_addr == 8'h50);
            if (wr_en) begin
                case (cap_addr)
                    8'h12: alert_mask[7:0]  <= cap_wdata;
                    8'h13: alert_mask[15:8] <= cap_wdata;
                    8'h19: TCPC_CONTROL     <= cap_wdata;
                    8'h1A: ROLE_CONTROL     <= cap_wdata;
                    8'h2F: RECEIVE_DETECT   <= cap_wdata;
                    8'h50: TRANSMIT         <= cap_wdata;
                    default: ;
                endcase
            end
        end
    end

    // ALERT_N follows the updated ALERT/ALERT_MASK registers one cycle later
    always_ff @(posedge CLK) begin
        if (!RESET) ALERT_N <= 1'b1;
        else        ALERT_N <= ~|(alert & alert_mask);
    end

endmodule

// File: tb/tb_tcpc_reg_bank.sv
// Directed bench for tcpc_reg_bank: handshake timing, register map, alerts, reset abort.
module tb_tcpc_reg_bank;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ALERT_SET;
    logic [7:0]  CC_STATUS_IN;
    logic [7:0]  TCPC_CONTROL, ROLE_CONTROL, RECEIVE_DETECT, TRANSMIT;
    logic        TRANSMIT_STB, ALERT_N;

    int total = 0;
    int bad   = 0;

    tcpc_reg_bank_if bus ();

    tcpc_reg_bank #(
        .VENDOR_ID (16'h1234),
        .PRODUCT_ID(16'h5678),
        .ACK_DELAY (1)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .bus           (bus.slave),
        .ALERT_SET     (ALERT_SET),
        .CC_STATUS_IN  (CC_STATUS_IN),
        .TCPC_CONTROL  (TCPC_CONTROL),
        .ROLE_CONTROL  (ROLE_CONTROL),
        .RECEIVE_DETECT(RECEIVE_DETECT),
        .TRANSMIT      (TRANSMIT),
        .TRANSMIT_STB  (TRANSMIT_STB),
        .ALERT_N       (ALERT_N)
    );

    always #5 CLK = ~CLK;

    // One full access; inputs driven and outputs sampled on negedges.
    // lat = edges from REQUEST sampling to ACK, held = ACK/RD stable one more
    // cycle, dropped = ACK/RD cleared after release, stb = STB at ack and next cycle.
    task automatic access(input logic rnw, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output logic held,
                          output logic dropped, output logic [1:0] stb);
        @(negedge CLK);
        bus.REQUEST = 1'b1; bus.RNW = rnw; bus.ADDR = a; bus.WR_DATA = d;
        lat = 0;
        while (bus.ACK !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        rd     = bus.RD_DATA;
        stb[0] = TRANSMIT_STB;
        bus.ADDR = 8'h7E; bus.WR_DATA = 8'hEE; bus.RNW = ~rnw;
        @(negedge CLK);
        stb[1] = TRANSMIT_STB;
        held = (bus.ACK === 1'b1) && (bus.RD_DATA === rd);
        bus.REQUEST = 1'b0;
        @(negedge CLK);
        dropped = (bus.ACK === 1'b0) && (bus.RD_DATA === 8'h00);
    endtask

    task automatic test_reset();
        @(negedge CLK); RESET = 1'b0;
        @(negedge CLK); @(negedge CLK); RESET = 1'b1;
        total++; if (bus.ACK !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.ACK); end
        total++; if (bus.RD_DATA !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", bus.RD_DATA); end
        total++; if (ALERT_N !== 1'b1) begin bad++; $display("FAIL reset_alert_n got=%b exp=1", ALERT_N); end
        total++; if (TRANSMIT_STB !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", TRANSMIT_STB); end
        total++; if ({TCPC_CONTROL, ROLE_CONTROL, RECEIVE_DETECT, TRANSMIT} !== 32'h000A0000) begin
            bad++; $display("FAIL reset_ctrl got=%h exp=000a0000", {TCPC_CONTROL, ROLE_CONTROL, RECEIVE_DETECT, TRANSMIT});
        end
    endtask

    task automatic test_read_defaults();
        logic [7:0] addrs [4] = '{8'h12, 8'h13, 8'h1A, 8'h00};
        logic [7:0] exps  [4] = '{8'hFF, 8'h7F, 8'h0A, 8'h34};
        logic [7:0] rd; int lat; logic held, dropped; logic [1:0] stb;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, addrs[i], 8'h00, rd, lat, held, dropped, stb);
            total++; if (rd !== exps[i]) begin bad++; $display("FAIL rd_default[%0h] got=%h exp=%h", addrs[i], rd, exps[i]); end
            total++; if (lat != 3) begin bad++; $display("FAIL ack_latency[%0h] got=%0d exp=3", addrs[i], lat); end
            total++; if (!held) begin bad++; $display("FAIL ack_hold[%0h] got=0 exp=1", addrs[i]); end
            total++; if (!dropped) begin bad++; $display("FAIL ack_drop[%0h] got=0 exp=1", addrs[i]); end
        end
        CC_STATUS_IN = 8'h5C;
        access(1'b1, 8'h1D, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h5C) begin bad++; $display("FAIL rd_cc_status got=%h exp=5c", rd); end
        access(1'b1, 8'h03, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h56) begin bad++; $display("FAIL rd_product_hi got=%h exp=56", rd); end
    endtask

    task automatic test_transmit();
        logic [7:0] rd; int lat; logic held, dropped; logic [1:0] stb;
        access(1'b0, 8'h50, 8'h05, rd, lat, held, dropped, stb);
        total++; if (TRANSMIT !== 8'h05) begin bad++; $display("FAIL tx_value got=%h exp=05", TRANSMIT); end
        total++; if (stb !== 2'b01) begin bad++; $display("FAIL tx_stb got=%b exp=01", stb); end
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL wr_rd_zero got=%h exp=00", rd); end
        access(1'b1, 8'h50, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h05) begin bad++; $display("FAIL rd_tx got=%h exp=05", rd); end
        total++; if (stb !== 2'b00) begin bad++; $display("FAIL rd_tx_stb got=%b exp=00", stb); end
        access(1'b0, 8'h01, 8'hAA, rd, lat, held, dropped, stb);
        access(1'b1, 8'h01, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h12) begin bad++; $display("FAIL ro_vendor_hi got=%h exp=12", rd); end
        access(1'b0, 8'h2F, 8'h3C, rd, lat, held, dropped, stb);
        total++; if (RECEIVE_DETECT !== 8'h3C) begin bad++; $display("FAIL rxdet got=%h exp=3c", RECEIVE_DETECT); end
    endtask

    task automatic pulse_alert(input logic [15:0] v);
        @(negedge CLK); ALERT_SET = v;
        @(negedge CLK); ALERT_SET = 16'h0000;
    endtask

    task automatic test_alert();
        logic [7:0] rd; int lat; logic held, dropped; logic [1:0] stb;
        pulse_alert(16'h0004);
        @(negedge CLK);
        total++; if (ALERT_N !== 1'b0) begin bad++; $display("FAIL alert_assert got=%b exp=0", ALERT_N); end
        access(1'b0, 8'h10, 8'h04, rd, lat, held, dropped, stb);
        total++; if (ALERT_N !== 1'b1) begin bad++; $display("FAIL alert_clear got=%b exp=1", ALERT_N); end
        access(1'b0, 8'h12, 8'hFB, rd, lat, held, dropped, stb);
        pulse_alert(16'h0004);
        @(negedge CLK); @(negedge CLK);
        total++; if (ALERT_N !== 1'b1) begin bad++; $display("FAIL alert_masked got=%b exp=1", ALERT_N); end
        access(1'b1, 8'h10, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h04) begin bad++; $display("FAIL alert_masked_rd got=%h exp=04", rd); end
        access(1'b0, 8'h12, 8'hFF, rd, lat, held, dropped, stb);
        @(negedge CLK);
        total++; if (ALERT_N !== 1'b0) begin bad++; $display("FAIL alert_unmask got=%b exp=0", ALERT_N); end
        access(1'b0, 8'h10, 8'h04, rd, lat, held, dropped, stb);
        pulse_alert(16'h0200);
        access(1'b1, 8'h11, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h02) begin bad++; $display("FAIL alert_hi_rd got=%h exp=02", rd); end
        access(1'b0, 8'h11, 8'h02, rd, lat, held, dropped, stb);
        @(negedge CLK);
        total++; if (ALERT_N !== 1'b1) begin bad++; $display("FAIL alert_hi_clear got=%b exp=1", ALERT_N); end
    endtask

    task automatic test_set_wins();
        logic [7:0] rd; int lat; logic held, dropped; logic [1:0] stb;
        // Hand-timed write so the ALERT_SET pulse lands on the access edge (3rd edge).
        @(negedge CLK);
        bus.REQUEST = 1'b1; bus.RNW = 1'b0; bus.ADDR = 8'h10; bus.WR_DATA = 8'h04;
        @(negedge CLK); @(negedge CLK);
        ALERT_SET = 16'h0004;
        @(negedge CLK);
        ALERT_SET = 16'h0000;
        total++; if (bus.ACK !== 1'b1) begin bad++; $display("FAIL set_wins_ack got=%b exp=1", bus.ACK); end
        bus.REQUEST = 1'b0;
        @(negedge CLK); @(negedge CLK);
        access(1'b1, 8'h10, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h04) begin bad++; $display("FAIL set_wins_rd got=%h exp=04", rd); end
        total++; if (ALERT_N !== 1'b0) begin bad++; $display("FAIL set_wins_alert_n got=%b exp=0", ALERT_N); end
        access(1'b0, 8'h10, 8'h04, rd, lat, held, dropped, stb);
    endtask

    task automatic test_back_to_back();
        int acks = 0, stbs = 0;
        logic prev = 1'b0;
        logic [7:0] rd; int lat; logic held, dropped; logic [1:0] stb;
        @(negedge CLK);
        bus.REQUEST = 1'b1; bus.RNW = 1'b0; bus.ADDR = 8'h50; bus.WR_DATA = 8'h07;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.ACK === 1'b1 && !prev) acks++;
            if (TRANSMIT_STB === 1'b1) stbs++;
            prev = bus.ACK;
        end
        bus.REQUEST = 1'b0;
        @(negedge CLK); @(negedge CLK);
        total++; if (acks != 1) begin bad++; $display("FAIL hold_ack_count got=%0d exp=1", acks); end
        total++; if (stbs != 1) begin bad++; $display("FAIL hold_write_count got=%0d exp=1", stbs); end
        total++; if (TRANSMIT !== 8'h07) begin bad++; $display("FAIL hold_tx got=%h exp=07", TRANSMIT); end
        access(1'b1, 8'h7E, 8'h00, rd, lat, held, dropped, stb);
        total++; if (rd !== 8'h00 || lat != 3) begin bad++; $display("FAIL unmapped got=%h/%0d exp=00/3", rd, lat); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; int lat; logic held, dropped; logic [1:0] stb;
        @(negedge CLK);
        bus.REQUEST = 1'b1; bus.RNW = 1'b0; bus.ADDR = 8'h19; bus.WR_DATA = 8'h33;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1; bus.REQUEST = 1'b0;
        @(negedge CLK); @(negedge CLK);
        total++; if (TCPC_CONTROL !== 8'h00) begin bad++; $display("FAIL abort_ctrl got=%h exp=00", TCPC_CONTROL); end
        total++; if (bus.ACK !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", bus.ACK); end
        total++; if (TRANSMIT !== 8'h00) begin bad++; $display("FAIL abort_tx_reset got=%h exp=00", TRANSMIT); end
        access(1'b0, 8'h19, 8'h33, rd, lat, held, dropped, stb);
        total++; if (TCPC_CONTROL !== 8'h33 || lat != 3) begin
            bad++; $display("FAIL post_abort got=%h/%0d exp=33/3", TCPC_CONTROL, lat);
        end
    endtask

    initial begin
        RESET = 1'b1; ALERT_SET = 16'h0000; CC_STATUS_IN = 8'h00;
        bus.REQUEST = 1'b0; bus.RNW = 1'b1; bus.ADDR = 8'h00; bus.WR_DATA = 8'h00;
        test_reset();
        test_read_defaults();
        test_transmit();
        test_alert();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcpc_reg_bank.md
Name: tcpc_reg_bank

Overview:
- Register file serving the single shared register-access channel that the client arbiter drives (REQUEST/RNW/ADDR/WR_DATA in, ACK/RD_DATA out).
- Holds the TCPC control/status registers, collects hardware alert events and drives the active-low ALERT_N line toward the TCPM.
- Exports control register values to the Tx/Rx/HardReset/CC logic.

Parameters:
- VENDOR_ID, 16'h0000, value of read-only regs 0x00/0x01 (low/high byte)
- PRODUCT_ID, 16'h0000, value of read-only regs 0x02/0x03
- ACK_DELAY, 1, wait cycles between request capture and ACK; legal range 0..15

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- REQUEST  in  1  access request from arbiter
- RNW  in  1  1=read, 0=write
- ADDR  in  8  register address
- WR_DATA  in  8  write data
- ACK  out  1  access complete; held until REQUEST drops
- RD_DATA  out  8  read data; valid while ACK=1
- ALERT_SET  in  16  per-bit one-cycle event pulses that set ALERT bits
- CC_STATUS_IN  in  8  live CC status, shown at reg 0x1D
- TCPC_CONTROL  out  8  reg 0x19 value
- ROLE_CONTROL  out  8  reg 0x1A value
- RECEIVE_DETECT  out  8  reg 0x2F value
- TRANSMIT  out  8  reg 0x50 value
- TRANSMIT_STB  out  1  one-cycle pulse on every write to 0x50
- ALERT_N  out  1  registered, active-low: 0 when any (ALERT & ALERT_MASK) bit is set

Behaviour:
- Reset (RESET=0 at a clock edge):
  - ACK=0, RD_DATA=0, TRANSMIT_STB=0, ALERT_N=1, FSM=IDLE, delay counter=0.
  - ALERT=16'h0000, ALERT_MASK=16'h7FFF, TCPC_CONTROL=0x00, ROLE_CONTROL=0x0A, RECEIVE_DETECT=0x00, TRANSMIT=0x00.
  - Reset mid-access aborts the access with no register update; FSM returns to IDLE.
- FSM, four-phase handshake:
  - IDLE:
    - REQUEST=1: capture ADDR, RNW, WR_DATA, load counter=ACK_DELAY, go to WAIT.
    - REQUEST=0: stay in IDLE.
  - WAIT:
    - counter>0: decrement.
    - counter=0: perform the access on this edge (write update, or load RD_DATA), set ACK=1, go to DONE.
    - With ACK_DELAY=0, ACK rises on the 2nd edge after REQUEST is sampled high.
    - REQUEST dropping in WAIT: access still completes; DONE then exits on the next edge.
  - DONE:
    - ACK=1 and RD_DATA stable while REQUEST=1.
    - REQUEST=0: ACK=0, RD_DATA=0, go to IDLE.
    - Exactly one access per REQUEST high period; a new access needs REQUEST low for at least one cycle.
  - Bus inputs are ignored outside IDLE; only the captured values are used.
- Write data RD_DATA is 0x00 after writes.
- Register map (unlisted addresses: read 0x00, write ignored, still ACKed):
  - 0x00/0x01 VENDOR_ID, RO
  - 0x02/0x03 PRODUCT_ID, RO
  - 0x10/0x11 ALERT low/high byte, write-1-to-clear
  - 0x12/0x13 ALERT_MASK low/high byte, RW
  - 0x19 TCPC_CONTROL, RW
  - 0x1A ROLE_CONTROL, RW
  - 0x1D CC_STATUS, RO; value is CC_STATUS_IN sampled at the access edge
  - 0x2F RECEIVE_DETECT, RW
  - 0x50 TRANSMIT, RW; write also drives TRANSMIT_STB=1 for exactly the following cycle
- Writes to RO registers are ignored.
- ALERT update on every clock edge: ALERT_next = (ALERT & ~clear_mask) | ALERT_SET.
  - clear_mask is nonzero only on the write edge to 0x10/0x11.
  - Set wins over clear for the same bit on the same edge.
- ALERT_N is registered from the post-update ALERT and ALERT_MASK, so it lags its cause by 1 cycle. Mask changes take effect the same way.
- RD_DATA returns the register value before any same-edge update; a read of ALERT concurrent with an ALERT_SET pulse returns the old value.

Test Plan:
- Reset, then read 0x12, 0x13, 0x1A, 0x00 with ACK_DELAY=1 → RD_DATA 0xFF, 0x7F, 0x0A, VENDOR_ID[7:0]. ACK rises 3 edges after REQUEST is sampled and holds until REQUEST falls, then drops next edge.
- Write 0x50←0x05 → TRANSMIT=0x05 and TRANSMIT_STB high exactly one cycle. Read 0x50 → 0x05. Write 0x01←0xAA → read 0x01 still returns VENDOR_ID[15:8].
- Pulse ALERT_SET=16'h0004 → ALERT_N goes 0 one cycle later. Write 0x10←0x04 → ALERT_N returns to 1. Repeat with mask 0x12←0xFB → ALERT_N stays 1 while the read of 0x10 returns 0x04.
- Write 0x10←0x04 on the same edge as ALERT_SET=16'h0004 → bit stays set; read 0x10 returns 0x04.
- Hold REQUEST high for 10 cycles → exactly one ACK assertion and one register write. Access to 0x7E → read 0x00, ACK still given.
- Assert RESET during WAIT of a write 0x19←0x33 → TCPC_CONTROL=0x00, ACK=0. The next access completes normally.
